// File: rtl/rv32imc_types.sv
// rtl/rv32imc_types.sv - shared cpu/memory-side types, including the memory arbiter FSM and source enums
package rv32imc_types;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_IMEM,
        ARB_DMEM
    } arb_state_t;

    typedef enum logic {
        ARB_SRC_IMEM,
        ARB_SRC_DMEM
    } arb_src_t;

    localparam int ARB_MASK_W = 4;

    function automatic logic mask_req(input logic [ARB_MASK_W-1:0] mask);
        return |mask;
    endfunction

endpackage

// File: rtl/mem_arb_wdt.sv
// rtl/mem_arb_wdt.sv - busy-cycle watchdog; expire fires on the WDT_CYCLES-th consecutive busy cycle without mem_resp
module mem_arb_wdt #(
    parameter int WDT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic busy,
    output logic expire
);

    localparam int CNT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WDT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (busy) begin
            count <= count + 1'b1;
        end
    end

    // Firing on the last counted cycle lets the FSM leave on the same edge the count reaches WDT_CYCLES.
    assign expire = busy && !clr && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - imem/dmem to shared memory port arbiter with watchdog; MEM_ARB_RR_EN enables round-robin ties
module mem_arbiter
    import rv32imc_types::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WDT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   imem_addr,
    input  logic [DATA_W/8-1:0] imem_rmask,
    output logic [DATA_W-1:0]   imem_rdata,
    output logic                imem_resp,
    input  logic [ADDR_W-1:0]   dmem_addr,
    input  logic [DATA_W/8-1:0] dmem_rmask,
    input  logic [DATA_W/8-1:0] dmem_wmask,
    input  logic [DATA_W-1:0]   dmem_wdata,
    output logic [DATA_W-1:0]   dmem_rdata,
    output logic                dmem_resp,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_rmask,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp,
    output logic                wdt_err
);

    arb_state_t state;
    logic       imem_req;
    logic       dmem_req;
    logic       grant_dmem;
    logic       wdt_expire;

    assign imem_req = |imem_rmask;
    assign dmem_req = (|dmem_rmask) || (|dmem_wmask);

`ifdef MEM_ARB_RR_EN
    arb_src_t last_winner;

    // Only contested grants move the pointer; uncontested ones leave fairness history alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_winner <= ARB_SRC_IMEM;
        end else if (state == ARB_IDLE && imem_req && dmem_req) begin
            last_winner <= grant_dmem ? ARB_SRC_DMEM : ARB_SRC_IMEM;
        end
    end

    always_comb begin
        grant_dmem = dmem_req;
        if (imem_req && dmem_req) begin
            grant_dmem = (last_winner == ARB_SRC_IMEM);
        end
    end
`else
    always_comb begin
        grant_dmem = dmem_req;
    end
`endif

    mem_arb_wdt #(
        .WDT_CYCLES(WDT_CYCLES)
    ) u_wdt (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == ARB_IDLE),
        .busy   ((state != ARB_IDLE) && !mem_resp),
        .expire (wdt_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_IDLE;
            mem_addr  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_rmask <= '0;
            mem_wmask <= '0;
            mem_wdata <= '0;
            wdt_err   <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_dmem) begin
                        state    <= ARB_DMEM;
                        mem_addr <= dmem_addr;
                        // A dmem request carrying a write mask is a store regardless of rmask.
                        if (|dmem_wmask) begin
                            mem_write <= 1'b1;
                            mem_rmask <= '0;
                            mem_wmask <= dmem_wmask;
                            mem_wdata <= dmem_wdata;
                        end else begin
                            mem_read  <= 1'b1;
                            mem_rmask <= dmem_rmask;
                            mem_wmask <= '0;
                        end
                    end else if (imem_req) begin
                        state     <= ARB_IMEM;
                        mem_addr  <= imem_addr;
                        mem_read  <= 1'b1;
                        mem_rmask <= imem_rmask;
                        mem_wmask <= '0;
                    end
                end
                ARB_IMEM, ARB_DMEM: begin
                    if (mem_resp || wdt_expire) begin
                        state     <= ARB_IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                    if (wdt_expire) begin
                        wdt_err <= 1'b1;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // A requester that flushed its mask before the response simply never sees it.
    assign imem_resp  = (state == ARB_IMEM) && mem_resp && imem_req;
    assign dmem_resp  = (state == ARB_DMEM) && mem_resp && dmem_req;
    assign imem_rdata = imem_resp ? mem_rdata : '0;
    assign dmem_rdata = dmem_resp ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (WDT_CYCLES=4)
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        wdt_err;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .WDT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rmask  (mem_rmask),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp),
        .wdt_err    (wdt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        imem_addr  = '0;
        imem_rmask = '0;
        dmem_addr  = '0;
        dmem_rmask = '0;
        dmem_wmask = '0;
        dmem_wdata = '0;
        mem_rdata  = '0;
        mem_resp   = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        cyc();
        mem_resp = 1'b1;
        mid();
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read: got %b want 0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write: got %b want 0", mem_write); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        checks++; if ({mem_rmask, mem_wmask} !== 8'h0) begin errors++; $display("FAIL rst_masks: got %h want 00", {mem_rmask, mem_wmask}); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (wdt_err !== 1'b0) begin errors++; $display("FAIL rst_wdt_err: got %b want 0", wdt_err); end
        checks++; if ({imem_resp, dmem_resp} !== 2'b00) begin errors++; $display("FAIL rst_resp: got %b want 00", {imem_resp, dmem_resp}); end
        cyc();
        mem_resp = 1'b0;
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_imem_fetch();
        imem_addr  = 32'h6000_0000;
        imem_rmask = 4'hF;
        mid();
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL fetch_req_cycle_read: got %b want 0", mem_read); end
        cyc();
        mid();
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL fetch_mem_read: got %b want 1", mem_read); end
        checks++; if (mem_addr !== 32'h6000_0000) begin errors++; $display("FAIL fetch_mem_addr: got %h want 60000000", mem_addr); end
        checks++; if (mem_rmask !== 4'hF) begin errors++; $display("FAIL fetch_mem_rmask: got %h want f", mem_rmask); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL fetch_mem_write: got %b want 0", mem_write); end
        cyc();
        for (int i = 0; i < 2; i++) begin
            mid();
            checks++; if (imem_resp !== 1'b0) begin errors++; $display("FAIL fetch_early_resp%0d: got %b want 0", i, imem_resp); end
            cyc();
        end
        mem_resp  = 1'b1;
        mem_rdata = 32'h0000_0013;
        mid();
        checks++; if (imem_resp !== 1'b1) begin errors++; $display("FAIL fetch_resp: got %b want 1", imem_resp); end
        checks++; if (imem_rdata !== 32'h13) begin errors++; $display("FAIL fetch_rdata: got %h want 13", imem_rdata); end
        checks++; if (dmem_resp !== 1'b0) begin errors++; $display("FAIL fetch_dmem_resp: got %b want 0", dmem_resp); end
        cyc();
        mem_resp   = 1'b0;
        imem_rmask = '0;
        mid();
        checks++; if (imem_resp !== 1'b0) begin errors++; $display("FAIL fetch_resp_once: got %b want 0", imem_resp); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL fetch_read_drop: got %b want 0", mem_read); end
        cyc();
    endtask

    task automatic test_tie();
        imem_addr  = 32'h100;
        imem_rmask = 4'hF;
        dmem_addr  = 32'h10;
        dmem_wmask = 4'h3;
        dmem_wdata = 32'hBEEF;
        cyc();
        mem_resp = 1'b1;
        mid();
        checks++; if ({mem_write, mem_read} !== 2'b10) begin errors++; $display("FAIL tie_first_write: got %b want 10", {mem_write, mem_read}); end
        checks++; if (mem_wmask !== 4'h3) begin errors++; $display("FAIL tie_wmask: got %h want 3", mem_wmask); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL tie_addr: got %h want 10", mem_addr); end
        checks++; if (mem_wdata !== 32'hBEEF) begin errors++; $display("FAIL tie_wdata: got %h want beef", mem_wdata); end
        checks++; if ({dmem_resp, imem_resp} !== 2'b10) begin errors++; $display("FAIL tie_store_resp: got %b want 10", {dmem_resp, imem_resp}); end
        cyc();
        mem_resp   = 1'b0;
        dmem_wmask = '0;
        mid();
        checks++; if ({mem_write, mem_read} !== 2'b00) begin errors++; $display("FAIL tie_bubble: got %b want 00", {mem_write, mem_read}); end
        cyc();
        mem_resp  = 1'b1;
        mem_rdata = 32'hAAAA_5555;
        mid();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL tie_fetch_issue: got read=%b addr=%h want 1 100", mem_read, mem_addr); end
        checks++; if (imem_resp !== 1'b1 || imem_rdata !== 32'hAAAA_5555) begin errors++; $display("FAIL tie_fetch_resp: got %b %h want 1 aaaa5555", imem_resp, imem_rdata); end
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_store_priority();
        dmem_addr  = 32'h20;
        dmem_rmask = 4'hF;
        dmem_wmask = 4'hC;
        dmem_wdata = 32'h1111_2222;
        cyc();
        mem_resp = 1'b1;
        mid();
        checks++; if ({mem_write, mem_read} !== 2'b10) begin errors++; $display("FAIL rw_is_store: got %b want 10", {mem_write, mem_read}); end
        checks++; if ({mem_rmask, mem_wmask} !== 8'h0C) begin errors++; $display("FAIL rw_masks: got %h want 0c", {mem_rmask, mem_wmask}); end
        checks++; if (dmem_resp !== 1'b1) begin errors++; $display("FAIL rw_resp: got %b want 1", dmem_resp); end
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_rr();
        logic [31:0] exp_addr [3];
`ifdef MEM_ARB_RR_EN
        exp_addr = '{32'h300, 32'h200, 32'h300};
`else
        exp_addr = '{32'h300, 32'h300, 32'h300};
`endif
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        imem_addr  = 32'h200;
        imem_rmask = 4'hF;
        dmem_addr  = 32'h300;
        dmem_rmask = 4'hF;
        cyc();
        for (int k = 0; k < 3; k++) begin
            mem_resp  = 1'b1;
            mem_rdata = 32'h50 + k;
            mid();
            checks++; if (mem_addr !== exp_addr[k]) begin errors++; $display("FAIL rr_grant%0d: got %h want %h", k, mem_addr, exp_addr[k]); end
            checks++; if ({imem_resp, dmem_resp} !== {exp_addr[k] == 32'h200, exp_addr[k] == 32'h300}) begin errors++; $display("FAIL rr_resp%0d: got %b", k, {imem_resp, dmem_resp}); end
            cyc();
            mem_resp = 1'b0;
            mid();
            checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rr_bubble%0d: got %b want 0", k, mem_read); end
            cyc();
        end
        imem_rmask = '0;
        dmem_rmask = '0;
        mem_resp   = 1'b1;
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_abandon();
        imem_addr  = 32'h400;
        imem_rmask = 4'hF;
        cyc();
        imem_addr = 32'h999;
        mid();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h400) begin errors++; $display("FAIL ab_issue: got %b %h want 1 400", mem_read, mem_addr); end
        cyc();
        imem_rmask = '0;
        mid();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h400) begin errors++; $display("FAIL ab_held: got %b %h want 1 400", mem_read, mem_addr); end
        cyc();
        mem_resp  = 1'b1;
        mem_rdata = 32'hDEAD;
        mid();
        checks++; if (imem_resp !== 1'b0) begin errors++; $display("FAIL ab_no_resp: got %b want 0", imem_resp); end
        cyc();
        mid();
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL ab_idle: got %b want 0", mem_read); end
        checks++; if ({imem_resp, dmem_resp} !== 2'b00) begin errors++; $display("FAIL idle_resp_ignored: got %b want 00", {imem_resp, dmem_resp}); end
        cyc();
        mem_resp = 1'b0;
        mid();
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL idle_stays: got %b want 00", {mem_read, mem_write}); end
        cyc();
        clear_inputs();
    endtask

    task automatic test_wdt();
        imem_addr  = 32'h800;
        imem_rmask = 4'hF;
        cyc();
        for (int i = 0; i < 4; i++) begin
            mid();
            checks++; if (mem_read !== 1'b1 || wdt_err !== 1'b0) begin errors++; $display("FAIL wdt_busy%0d: got read=%b err=%b want 1 0", i, mem_read, wdt_err); end
            cyc();
        end
        imem_rmask = '0;
        mid();
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL wdt_read_drop: got %b want 0", mem_read); end
        checks++; if (wdt_err !== 1'b1) begin errors++; $display("FAIL wdt_err_set: got %b want 1", wdt_err); end
        checks++; if (imem_resp !== 1'b0) begin errors++; $display("FAIL wdt_no_resp: got %b want 0", imem_resp); end
        cyc();
        dmem_addr  = 32'h500;
        dmem_rmask = 4'hF;
        cyc();
        mem_resp  = 1'b1;
        mem_rdata = 32'h1234;
        mid();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h500) begin errors++; $display("FAIL wdt_next_issue: got %b %h want 1 500", mem_read, mem_addr); end
        checks++; if (dmem_resp !== 1'b1 || dmem_rdata !== 32'h1234) begin errors++; $display("FAIL wdt_next_resp: got %b %h want 1 1234", dmem_resp, dmem_rdata); end
        cyc();
        mem_resp   = 1'b0;
        dmem_rmask = '0;
        mid();
        checks++; if (wdt_err !== 1'b1) begin errors++; $display("FAIL wdt_err_sticky: got %b want 1", wdt_err); end
        cyc();
    endtask

    task automatic test_reset_mid();
        dmem_addr  = 32'h600;
        dmem_wmask = 4'hF;
        dmem_wdata = 32'h77;
        cyc();
        mid();
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rm_write: got %b want 1", mem_write); end
        rst      = 1'b0;
        mem_resp = 1'b1;
        #1;
        checks++; if ({mem_write, mem_read} !== 2'b00) begin errors++; $display("FAIL rm_async_req: got %b want 00", {mem_write, mem_read}); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wmask !== 4'h0) begin errors++; $display("FAIL rm_async_regs: got %h %h %h want 0", mem_addr, mem_wdata, mem_wmask); end
        checks++; if (wdt_err !== 1'b0) begin errors++; $display("FAIL rm_wdt_clear: got %b want 0", wdt_err); end
        checks++; if (dmem_resp !== 1'b0) begin errors++; $display("FAIL rm_resp_lost: got %b want 0", dmem_resp); end
        cyc();
        rst        = 1'b1;
        dmem_wmask = '0;
        mid();
        checks++; if (dmem_resp !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL rm_stale_resp: got %b %b want 0 0", dmem_resp, mem_write); end
        cyc();
        mem_resp   = 1'b0;
        dmem_addr  = 32'h700;
        dmem_rmask = 4'hF;
        cyc();
        mem_resp  = 1'b1;
        mem_rdata = 32'hCAFE;
        mid();
        checks++; if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 32'h700) begin errors++; $display("FAIL rm_fresh_issue: got %b %h want 10 700", {mem_read, mem_write}, mem_addr); end
        checks++; if (dmem_resp !== 1'b1 || dmem_rdata !== 32'hCAFE) begin errors++; $display("FAIL rm_fresh_resp: got %b %h want 1 cafe", dmem_resp, dmem_rdata); end
        cyc();
        clear_inputs();
        cyc();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_imem_fetch();
        test_tie();
        test_store_priority();
        test_rr();
        test_abandon();
        test_wdt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
